key_expand: RTL and testbench
=============================

KEY_EXPAND -- requirements
Module: key_expand

Interface
REQ-001 SHALL have no parameters; AES-256 only: Nk=8, 14 rounds, round counter 0..14.
REQ-002 clk  input  1  global clock; all state SHALL update on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 key_load  input  1  single-cycle pulse; captures key_in.
REQ-005 key_in  input  256  cipher key, word W0 in [255:224] through W7 in [31:0].
REQ-006 blk_start  input  1  single-cycle pulse; restores the captured key at the start of a block.
REQ-007 rnd_cnt  input  4  round counter from the sequencer, 0..14.
REQ-008 step  input  3  step counter from the sequencer, 0..4.
REQ-009 sub_out  input  32  S-Box result from the sub-bytes stage.
REQ-010 k3  output  32  working word K3, fed to the sub-bytes stage.
REQ-011 k7_rot  output  32  K7 rotated left by one byte ({K7[23:0],K7[31:24]}), fed to the sub-bytes stage.
REQ-012 rnd_key  output  128  current round key.
REQ-013 key_ready  output  1  high when a key is held and the working register equals the expanded state for the current round.
REQ-014 exp_done  output  1  high once all 13 expansion updates of the block are complete.

Function
REQ-015 Working register SHALL be K0..K7 (8 x 32 bit); a 256-bit shadow register SHALL hold the loaded key.
REQ-016 key_load SHALL load both shadow and working register from key_in, set rcon=0x01, clear exp_cnt, and enter READY.
REQ-017 blk_start SHALL copy shadow into the working register, set rcon=0x01, clear exp_cnt, and enter READY.
REQ-018 blk_start SHALL be ignored in IDLE.
REQ-019 key_load and blk_start asserted in the same cycle: key_load SHALL win.
REQ-020 The key SHALL be reloaded in any state, aborting an expansion in progress.
REQ-021 States: IDLE (no key), READY (exp_cnt=0), EXPAND (1<=exp_cnt<=12), DONE (exp_cnt=13).
REQ-022 State transitions:
- READY->EXPAND on the first update.
- EXPAND->DONE on the 13th update.
- DONE->READY on blk_start.
REQ-023 An update SHALL occur only at the clock edge where step==1, 1<=rnd_cnt<=13, and state is READY or EXPAND.
- sub_out is then the S-Box of the word the sub-bytes stage latched at step 0.
REQ-024 Odd rnd_cnt update (sub_out = SubWord(k7_rot)):
- K0' = K0 ^ sub_out ^ {rcon,24'h0}
- K1' = K1 ^ K0'
- K2' = K2 ^ K1'
- K3' = K3 ^ K2'
- K4..K7 unchanged.
- Then rcon <= xtime(rcon): rcon<<1, XOR 0x1B on carry.
REQ-025 Even rnd_cnt update (sub_out = SubWord(k3)):
- K4' = K4 ^ sub_out
- K5' = K5 ^ K4'
- K6' = K6 ^ K5'
- K7' = K7 ^ K6'
- K0..K3 unchanged; rcon unchanged.
REQ-026 Each update SHALL increment exp_cnt, saturating at 13.
REQ-027 In DONE, at rnd_cnt 0 or 14, and at step!=1, K0..K7 SHALL be held.
REQ-028 rnd_key SHALL be combinational:
- {K0,K1,K2,K3} when rnd_cnt[0]==0.
- {K4,K5,K6,K7} when rnd_cnt[0]==1.
REQ-029 k3 and k7_rot SHALL be combinational from the working register, valid every cycle.
REQ-030 The key SHALL be usable the cycle after the key_load/blk_start edge (latency 1).
REQ-031 key_ready SHALL be high in READY, EXPAND and DONE, and low in IDLE.
REQ-032 exp_done SHALL be high only in DONE.
REQ-033 An update request at rnd_cnt >= 15 SHALL be ignored with no state change.

Reset
REQ-034 reset_n low SHALL immediately clear K0..K7, shadow, exp_cnt, and all outputs to 0.
REQ-035 reset_n low SHALL immediately set rcon=0x01 and state=IDLE.
REQ-036 Reset mid-expansion SHALL discard all key material; key_load is required before further use.

Verification
REQ-037 Bench SHALL drive sub_out from a reference S-Box of the word selected at step 0, one cycle later.
REQ-038 Load key 000102..1f (FIPS-197 C.3), run rnd 0..14 -> required response:
- rnd 1 rnd_key = 101112131415161718191a1b1c1d1e1f
- rnd 2 rnd_key = a573c29fa176c498a97fce93a572c09c
- rnd 14 rnd_key = 24fc79ccbf0979e9371ac23c6d68de36
- exp_done=1 after the rnd 13 update.
REQ-039 After REQ-038, pulse blk_start -> rnd_key = 000102..0f, exp_done=0, and an identical second sequence is produced.
REQ-040 key_load during rnd 6 with a new key -> the new key appears next cycle, rcon=0x01, exp_cnt=0, and the old key is gone.
REQ-041 Hold step at 1 with rnd_cnt=0, then rnd_cnt=14, then rnd_cnt=15 -> no register change.
REQ-042 Assert reset_n low at rnd 9 step 1 -> all outputs 0, key_ready=0; a subsequent blk_start is ignored.
REQ-043 key_load and blk_start in the same cycle with a different key_in -> key_in is loaded into both shadow and working register.

Source files
------------

// File: rtl/key_expand.sv
// rtl/key_expand.sv - AES-256 round-key expansion: 8-word working register advanced in place,
// one half-schedule per round, with a shadow copy of the cipher key for per-block restart.
module key_expand (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         key_load,
   input  logic [255:0] key_in,
   input  logic         blk_start,
   input  logic [3:0]   rnd_cnt,
   input  logic [2:0]   step,
   input  logic [31:0]  sub_out,
   output logic [31:0]  k3,
   output logic [31:0]  k7_rot,
   output logic [127:0] rnd_key,
   output logic         key_ready,
   output logic         exp_done
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_READY  = 2'd1,
      S_EXPAND = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [3:0] LAST_UPDATE = 4'd13;

   state_t         state_q, state_d;
   logic [255:0]   work_q, work_d;
   logic [255:0]   shadow_q, shadow_d;
   logic [7:0]     rcon_q, rcon_d;
   logic [3:0]     exp_cnt_q, exp_cnt_d;

   logic [31:0]    w0, w1, w2, w3, w4, w5, w6, w7;
   logic [31:0]    n0, n1, n2, n3, n4, n5, n6, n7;
   logic           upd;
   logic [7:0]     rcon_next;

   assign w0 = work_q[255:224];
   assign w1 = work_q[223:192];
   assign w2 = work_q[191:160];
   assign w3 = work_q[159:128];
   assign w4 = work_q[127:96];
   assign w5 = work_q[95:64];
   assign w6 = work_q[63:32];
   assign w7 = work_q[31:0];

   // Updates only land on step 1, once sub_out carries the S-Box of the step-0 word
   assign upd = (step == 3'd1) && (rnd_cnt >= 4'd1) && (rnd_cnt <= LAST_UPDATE) &&
                ((state_q == S_READY) || (state_q == S_EXPAND));

   assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

   always_comb begin
      n0 = w0 ^ sub_out ^ {rcon_q, 24'h0};
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
      n4 = w4 ^ sub_out;
      n5 = w5 ^ n4;
      n6 = w6 ^ n5;
      n7 = w7 ^ n6;
   end

   always_comb begin
      state_d   = state_q;
      work_d    = work_q;
      shadow_d  = shadow_q;
      rcon_d    = rcon_q;
      exp_cnt_d = exp_cnt_q;
      if (key_load) begin
         work_d    = key_in;
         shadow_d  = key_in;
         rcon_d    = 8'h01;
         exp_cnt_d = 4'd0;
         state_d   = S_READY;
      end else if (blk_start && (state_q != S_IDLE)) begin
         work_d    = shadow_q;
         rcon_d    = 8'h01;
         exp_cnt_d = 4'd0;
         state_d   = S_READY;
      end else if (upd) begin
         if (rnd_cnt[0]) begin
            work_d = {n0, n1, n2, n3, w4, w5, w6, w7};
            rcon_d = rcon_next;
         end else begin
            work_d = {w0, w1, w2, w3, n4, n5, n6, n7};
         end
         exp_cnt_d = (exp_cnt_q == LAST_UPDATE) ? LAST_UPDATE : exp_cnt_q + 4'd1;
         state_d   = (exp_cnt_d == LAST_UPDATE) ? S_DONE : S_EXPAND;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         work_q    <= '0;
         shadow_q  <= '0;
         rcon_q    <= 8'h01;
         exp_cnt_q <= 4'd0;
      end else begin
         state_q   <= state_d;
         work_q    <= work_d;
         shadow_q  <= shadow_d;
         rcon_q    <= rcon_d;
         exp_cnt_q <= exp_cnt_d;
      end
   end

   assign k3        = w3;
   assign k7_rot    = {w7[23:0], w7[31:24]};
   assign rnd_key   = rnd_cnt[0] ? work_q[127:0] : work_q[255:128];
   assign key_ready = (state_q != S_IDLE);
   assign exp_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_key_expand.sv
// tb/tb_key_expand.sv - self-checking bench for key_expand against a software AES-256 key schedule.
module tb_key_expand;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         key_load;
   logic [255:0] key_in;
   logic         blk_start;
   logic [3:0]   rnd_cnt;
   logic [2:0]   step;
   logic [31:0]  sub_out;
   logic [31:0]  k3;
   logic [31:0]  k7_rot;
   logic [127:0] rnd_key;
   logic         key_ready;
   logic         exp_done;

   key_expand dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .key_load  (key_load),
      .key_in    (key_in),
      .blk_start (blk_start),
      .rnd_cnt   (rnd_cnt),
      .step      (step),
      .sub_out   (sub_out),
      .k3        (k3),
      .k7_rot    (k7_rot),
      .rnd_key   (rnd_key),
      .key_ready (key_ready),
      .exp_done  (exp_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           rnd;
      logic [127:0] rk;
   } kat_t;

   kat_t         kat [3];
   logic [31:0]  w_exp [0:59];
   logic [127:0] exp_q [$];
   int           tests = 0;
   int           fails = 0;

   localparam logic [255:0] KEY_A = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [255:0] KEY_B = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [255:0] KEY_C = 256'h0123456789abcdeffedcba98765432100f1e2d3c4b5a69788796a5b4c3d2e1f0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] e;
      r = 8'h01;
      e = 8'hfe;
      for (int i = 7; i >= 0; i--) begin
         r = gf_mul(r, r);
         if (e[i]) r = gf_mul(r, a);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] subword(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   task automatic expand(input logic [255:0] key);
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 8; i++) w_exp[i] = key[255 - 32*i -: 32];
      for (int i = 8; i < 60; i++) begin
         t = w_exp[i-1];
         if (i % 8 == 0) begin
            t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end else if (i % 8 == 4) begin
            t = subword(t);
         end
         w_exp[i] = w_exp[i-8] ^ t;
      end
   endtask

   function automatic logic [127:0] rk(input int r);
      return {w_exp[4*r], w_exp[4*r+1], w_exp[4*r+2], w_exp[4*r+3]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_load(input logic [255:0] k, input logic with_blk);
      key_in    = k;
      key_load  = 1'b1;
      blk_start = with_blk;
      tick();
      key_load  = 1'b0;
      blk_start = 1'b0;
   endtask

   task automatic pulse_blk();
      blk_start = 1'b1;
      tick();
      blk_start = 1'b0;
   endtask

   task automatic check_key_halves(input string name, input logic [255:0] k);
      logic [3:0] save;
      save = rnd_cnt;
      rnd_cnt = 4'd0;
      #1 chk({name, " lo"}, {128'h0, rnd_key}, {128'h0, k[255:128]});
      rnd_cnt = 4'd1;
      #1 chk({name, " hi"}, {128'h0, rnd_key}, {128'h0, k[127:0]});
      rnd_cnt = save;
      #1;
   endtask

   // Sequencer model: rounds 0..last, steps 0..4; sub_out follows the step-0 word by one cycle
   task automatic run_block(input int last, input bit use_kat);
      logic [127:0] want;
      logic [31:0]  sel;
      for (int r = 0; r <= last; r++) begin
         rnd_cnt = r[3:0];
         step    = 3'd0;
         sub_out = 32'h0;
         exp_q.push_back(rk(r));
         @(negedge clk);
         want = exp_q.pop_front();
         chk($sformatf("rnd_key r%0d", r), {128'h0, rnd_key}, {128'h0, want});
         chk($sformatf("exp_done r%0d", r), {255'h0, exp_done}, {255'h0, (r == 14)});
         chk($sformatf("key_ready r%0d", r), {255'h0, key_ready}, 256'h1);
         if (use_kat)
            for (int k = 0; k < 3; k++)
               if (kat[k].rnd == r)
                  chk($sformatf("kat r%0d", r), {128'h0, rnd_key}, {128'h0, kat[k].rk});
         sel = r[0] ? k7_rot : k3;
         tick();
         step    = 3'd1;
         sub_out = subword(sel);
         tick();
         sub_out = 32'h0;
         for (int s = 2; s <= 4; s++) begin
            step = s[2:0];
            tick();
         end
      end
   endtask

   initial begin
      kat[0] = '{1,  128'h101112131415161718191a1b1c1d1e1f};
      kat[1] = '{2,  128'ha573c29fa176c498a97fce93a572c09c};
      kat[2] = '{14, 128'h24fc79ccbf0979e9371ac23c6d68de36};

      reset_n   = 1'b0;
      key_load  = 1'b0;
      key_in    = '0;
      blk_start = 1'b0;
      rnd_cnt   = 4'd0;
      step      = 3'd0;
      sub_out   = 32'h0;
      #1;
      chk("reset rnd_key", {128'h0, rnd_key}, 256'h0);
      chk("reset k3/k7_rot", {192'h0, k3, k7_rot}, 256'h0);
      chk("reset flags", {254'h0, key_ready, exp_done}, 256'h0);
      repeat (2) tick();
      reset_n = 1'b1;
      tick();

      pulse_blk();
      chk("idle blk_start ignored", {255'h0, key_ready}, 256'h0);

      // FIPS-197 C.3 key, full block, then restart from shadow
      expand(KEY_A);
      pulse_load(KEY_A, 1'b0);
      chk("load ready", {255'h0, key_ready}, 256'h1);
      run_block(14, 1'b1);

      step = 3'd1;
      rnd_cnt = 4'd1;
      sub_out = 32'hffffffff;
      repeat (2) tick();
      step = 3'd0;
      rnd_cnt = 4'd0;
      #1 chk("done hold lo", {128'h0, rnd_key}, {128'h0, rk(14)});
      rnd_cnt = 4'd1;
      #1 chk("done hold hi", {128'h0, rnd_key}, {128'h0, rk(13)});

      pulse_blk();
      check_key_halves("blk_start restore", KEY_A);
      chk("blk_start exp_done", {255'h0, exp_done}, 256'h0);
      run_block(14, 1'b1);

      // Reload mid-expansion
      pulse_blk();
      run_block(5, 1'b0);
      rnd_cnt = 4'd6;
      step    = 3'd0;
      pulse_load(KEY_B, 1'b0);
      chk("reload rnd6", {128'h0, rnd_key}, {128'h0, KEY_B[255:128]});
      chk("reload exp_done", {255'h0, exp_done}, 256'h0);
      check_key_halves("reload", KEY_B);
      expand(KEY_B);
      run_block(14, 1'b0);
      pulse_blk();
      check_key_halves("shadow after reload", KEY_B);

      // key_load beats blk_start
      pulse_load(KEY_C, 1'b1);
      check_key_halves("load+blk", KEY_C);
      pulse_blk();
      check_key_halves("load+blk shadow", KEY_C);

      // No update outside rounds 1..13
      step = 3'd1;
      foreach (kat[k]) begin end
      for (int i = 0; i < 3; i++) begin
         rnd_cnt = (i == 0) ? 4'd0 : (i == 1) ? 4'd14 : 4'd15;
         sub_out = $urandom;
         repeat (2) tick();
      end
      step = 3'd0;
      check_key_halves("hold rnd 0/14/15", KEY_C);
      chk("hold k3", {224'h0, k3}, {224'h0, KEY_C[159:128]});
      chk("hold k7_rot", {224'h0, k7_rot}, {224'h0, KEY_C[23:0], KEY_C[31:24]});
      expand(KEY_C);
      run_block(14, 1'b0);

      // Asynchronous reset mid-expansion
      pulse_blk();
      run_block(8, 1'b0);
      rnd_cnt = 4'd9;
      step    = 3'd0;
      tick();
      step    = 3'd1;
      sub_out = subword(k7_rot);
      #2 reset_n = 1'b0;
      #1;
      chk("async reset rnd_key", {128'h0, rnd_key}, 256'h0);
      chk("async reset k3/k7_rot", {192'h0, k3, k7_rot}, 256'h0);
      chk("async reset flags", {254'h0, key_ready, exp_done}, 256'h0);
      tick();
      reset_n = 1'b1;
      step    = 3'd0;
      tick();
      pulse_blk();
      chk("post-reset blk_start", {255'h0, key_ready}, 256'h0);
      check_key_halves("post-reset key gone", 256'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
